des_kat_selftest: RTL and testbench
===================================

Name: des_kat_selftest

Overview:
- Hardware known-answer self-test initiator for the des core. Drives the core's input side and checks its output side.
- Phase ENC: encrypts 64 walking-one plaintexts under a fixed key and compares each result against an answer ROM.
- Phase DEC: decrypts the ROM answers and compares each result against the walking-one plaintexts.
- Sits beside des in the crypto subsystem and reports pass/fail to the control/status logic.

Parameters:
- KEY, 64'h0101010101010101, key applied in both phases.
- TIMEOUT, 256, maximum idle cycles while waiting for des valid before aborting.
- DEC_EN, 1, 1 runs phase DEC after ENC; 0 finishes after ENC.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-low
- start_i  in  1  start request, sampled in IDLE only
- des_mode_o  out  1  to des mode_i; 0 = encrypt, 1 = decrypt
- des_key_o  out  [0:63]  to des key_i
- des_data_o  out  [0:63]  to des data_i
- des_valid_o  out  1  to des valid_i
- des_data_i  in  [0:63]  from des data_o
- des_valid_i  in  1  from des valid_o
- rom_addr_o  out  6  answer ROM address; ROM read is asynchronous
- rom_data_i  in  [0:63]  answer ROM data (NIST SP800-17 variable-plaintext answers)
- busy_o  out  1  test in progress
- done_o  out  1  one-cycle pulse at completion or abort
- pass_o  out  1  result of last run; held until next start
- err_cnt_o  out  8  mismatch count, saturates at 255
- first_err_o  out  7  {phase, index} of first mismatch; 7'h7F if none
- timeout_o  out  1  last run aborted on timeout

Behaviour:
- Reset (reset_i=0 at posedge clk_i):
  - State goes to IDLE. des_valid_o, busy_o, done_o, pass_o, timeout_o = 0.
  - des_mode_o = 0, des_data_o = 0, des_key_o = KEY, rom_addr_o = 0.
  - err_cnt_o = 0, first_err_o = 7'h7F.
  - A reset mid-run aborts the run with no done_o pulse.
- States: IDLE -> ENC -> DEC -> FIN -> IDLE. ENC goes straight to FIN when DEC_EN = 0.
- IDLE:
  - start_i=1 enters ENC on the next cycle. busy_o=1 from that cycle.
  - Entering ENC clears pass_o, err_cnt_o, first_err_o and timeout_o.
  - des_valid_i is ignored in IDLE. start_i is ignored outside IDLE.
- Issue side (per phase):
  - in_idx runs 0..63. des_valid_o=1 for exactly 64 consecutive cycles starting with the first phase cycle, then 0.
  - ENC: des_data_o has only bit[in_idx] set, i.e. 64'h8000000000000000 >> in_idx.
  - DEC: des_data_o = rom_data_i with rom_addr_o = in_idx.
  - des_mode_o is constant within a phase (ENC 0, DEC 1).
- Check side:
  - out_idx starts at 0 at phase entry and increments on each des_valid_i=1 cycle.
  - ENC: rom_addr_o = out_idx. Expected value = rom_data_i.
  - DEC: expected value = walking_one(out_idx).
  - Issue and check overlap; the des pipeline latency is arbitrary and is not a parameter.
  - On mismatch: err_cnt_o increments, saturating at 255. first_err_o is written only while it holds 7'h7F; the phase bit is 0 for ENC, 1 for DEC.
- Phase end: the cycle that consumes the 64th output moves the FSM to the next phase (DEC or FIN). Each phase therefore drains fully before the mode changes.
- Timeout:
  - Counter clears on phase entry and on every des_valid_i.
  - When the counter reaches TIMEOUT: timeout_o=1, des_valid_o=0, go to FIN.
- FIN (one cycle): done_o=1. pass_o = (err_cnt_o==0 && !timeout_o). busy_o=0 from the following IDLE cycle.
- Simultaneous events: issue and check in the same cycle are independent. A mismatch and a timeout in the same cycle: the mismatch is counted and the timeout is also flagged.

Decomposition:
- Package des_kat_pkg holds:
  - state enum.
  - KAT_N = 64.
  - DEFAULT_KEY constant.
  - walking_one(idx) function, shared by issue and check.
  - FIRST_ERR_NONE = 7'h7F.
- No sub-module. The des core is instantiated by the parent. The bench instantiates des, this block and a ROM model.

Test Plan:
- Reset low 2 cycles, release, no start -> all outputs at reset values, des_valid_o=0 for 100 cycles.
- start_i pulse with real des and correct ROM -> ENC issues 8000000000000000...0000000000000001 and ROM[0] expected 95F8A5E5DD31D900, ROM[63] 166B40B44ABA4BD6; done_o one pulse, pass_o=1, err_cnt_o=0, first_err_o=7F.
- ROM[5] corrupted (bit0 flipped) -> ENC index 5 mismatch and DEC index 5 mismatch; err_cnt_o=2, first_err_o=7'h05, pass_o=0.
- des stub that never asserts valid -> done_o after 64+TIMEOUT cycles, timeout_o=1, pass_o=0, des_valid_o low after 64 issues.
- Reset asserted at ENC out_idx=30 -> IDLE next cycle, no done_o; a new start then completes with pass_o=1.
- DEC_EN=0, start held high for 3 cycles -> single ENC run of 64 issues, one done_o, no DEC (des_mode_o stays 0).

Source files
------------

// File: rtl/des_kat_pkg.sv
// Shared definitions for the DES known-answer self-test initiator.
// Holds the FSM state type, vector count, default key, the "no error"
// marker for first_err, and the walking-one generator used by both the
// issue side (ENC plaintexts) and the check side (DEC expected values).
package des_kat_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEnc,
    StDec,
    StFin
  } state_e;

  localparam int unsigned KAT_N          = 64;
  localparam logic [0:63] DEFAULT_KEY    = 64'h0101_0101_0101_0101;
  localparam logic [6:0]  FIRST_ERR_NONE = 7'h7F;

  // Only bit[idx] set, with bit 0 as the MSB (matches des [0:63] ordering).
  function automatic logic [0:63] walking_one(input logic [5:0] idx);
    logic [0:63] w;
    w      = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/des_kat_selftest.sv
// Known-answer self-test initiator for the des core.
// ENC phase: encrypts 64 walking-one plaintexts under KEY and checks each
// result against the answer ROM. DEC phase (DEC_EN=1): decrypts the ROM
// answers and checks against the walking-one plaintexts.
// Ports:
//   clk_i, reset_i    clock, synchronous active-low reset
//   start_i           start request (IDLE only)
//   des_*_o / des_*_i drive / observe the des core
//   rom_addr_o/data_i asynchronous answer ROM
//   busy_o, done_o    run in progress, one-cycle completion pulse
//   pass_o            last run passed (held until next start)
//   err_cnt_o         saturating mismatch count
//   first_err_o       {phase, index} of first mismatch, 7'h7F if none
//   timeout_o         last run aborted waiting for des output
module des_kat_selftest
  import des_kat_pkg::*;
#(
  parameter logic [0:63] KEY     = DEFAULT_KEY,
  parameter int unsigned TIMEOUT = 256,
  parameter bit          DEC_EN  = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic        des_mode_o,
  output logic [0:63] des_key_o,
  output logic [0:63] des_data_o,
  output logic        des_valid_o,
  input  logic [0:63] des_data_i,
  input  logic        des_valid_i,
  output logic [5:0]  rom_addr_o,
  input  logic [0:63] rom_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [7:0]  err_cnt_o,
  output logic [6:0]  first_err_o,
  output logic        timeout_o
);

  localparam int unsigned    TW          = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMEOUT_VAL = TW'(TIMEOUT);
  localparam logic [6:0]     IDX_END     = 7'(KAT_N);
  localparam logic [6:0]     IDX_LAST    = 7'(KAT_N - 1);

  state_e          state_q, state_d;
  logic [6:0]      in_idx_q, in_idx_d;
  logic [6:0]      out_idx_q, out_idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic [6:0]      first_err_q, first_err_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;

  logic            in_phase, issuing, timed_out, mismatch;
  logic [0:63]     expected;

  assign in_phase  = (state_q == StEnc) || (state_q == StDec);
  assign issuing   = in_phase && (in_idx_q != IDX_END);
  assign timed_out = in_phase && (timer_q == TIMEOUT_VAL);

  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    out_idx_d   = out_idx_q;
    timer_d     = timer_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;

    des_valid_o = issuing && !timed_out;
    des_mode_o  = (state_q == StDec);
    des_data_o  = '0;
    rom_addr_o  = '0;
    expected    = walking_one(out_idx_q[5:0]);

    // The ROM serves the check side in ENC and the issue side in DEC.
    unique case (state_q)
      StEnc: begin
        rom_addr_o = out_idx_q[5:0];
        expected   = rom_data_i;
        if (issuing) des_data_o = walking_one(in_idx_q[5:0]);
      end
      StDec: begin
        rom_addr_o = in_idx_q[5:0];
        if (issuing) des_data_o = rom_data_i;
      end
      default: ;
    endcase

    mismatch = in_phase && des_valid_i && (des_data_i != expected);

    if (des_valid_o) in_idx_d = in_idx_q + 7'd1;

    if (mismatch) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      if (first_err_q == FIRST_ERR_NONE) first_err_d = {state_q == StDec, out_idx_q[5:0]};
    end

    // Timer only runs once all inputs are issued, i.e. while waiting on des.
    if (in_phase) begin
      if (des_valid_i) begin
        out_idx_d = out_idx_q + 7'd1;
        timer_d   = '0;
      end else if (!issuing) begin
        timer_d = timer_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StEnc;
          in_idx_d    = '0;
          out_idx_d   = '0;
          timer_d     = '0;
          err_cnt_d   = '0;
          first_err_d = FIRST_ERR_NONE;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      StEnc, StDec: begin
        if (timed_out) begin
          timeout_d = 1'b1;
          state_d   = StFin;
        end else if (des_valid_i && (out_idx_q == IDX_LAST)) begin
          if ((state_q == StEnc) && DEC_EN) begin
            state_d   = StDec;
            in_idx_d  = '0;
            out_idx_d = '0;
            timer_d   = '0;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Uses the _d values so a last-cycle mismatch or timeout is included.
    if ((state_d == StFin) && (state_q != StFin)) begin
      pass_d = (err_cnt_d == 8'd0) && !timeout_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= StIdle;
      in_idx_q    <= '0;
      out_idx_q   <= '0;
      timer_q     <= '0;
      err_cnt_q   <= '0;
      first_err_q <= FIRST_ERR_NONE;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_idx_q    <= in_idx_d;
      out_idx_q   <= out_idx_d;
      timer_q     <= timer_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign des_key_o   = KEY;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StFin);
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_cnt_q;
  assign first_err_o = first_err_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_des_kat_selftest.sv
// Bench for des_kat_selftest. A stand-in cipher (rotate + xor, invertible)
// with fixed pipeline latency replaces des; the answer ROM is filled with
// that cipher's encryptions of the walking-one vectors. Instance a uses
// DEC_EN=1, instance b DEC_EN=0; sel chooses which one owns the cipher.
module tb_des_kat_selftest;

  localparam int unsigned TO  = 256;
  localparam int unsigned LAT = 5;
  localparam logic [63:0] C   = 64'hA5A5_0F0F_3C3C_9696;

  typedef struct packed {
    logic        mode;
    logic [63:0] data;
  } iss_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, start_a, start_b, sel, dead;

  logic        mode_a, valid_a, busy_a, done_a, pass_a, tout_a;
  logic [0:63] key_a, data_a;
  logic [5:0]  addr_a;
  logic [7:0]  err_a;
  logic [6:0]  first_a;
  logic        mode_b, valid_b, busy_b, done_b, pass_b, tout_b;
  logic [0:63] key_b, data_b;
  logic [5:0]  addr_b;
  logic [7:0]  err_b;
  logic [6:0]  first_b;

  logic [63:0]    rom [64];
  logic [63:0]    pd [LAT];
  logic [LAT-1:0] pv = '0;
  logic           stub_v, vin_a, vin_b, in_v, in_m;
  logic [63:0]    in_d;

  iss_t sb[$];
  int tests = 0, fails = 0;
  int done_cnt_a = 0, done_cnt_b = 0, outs_a = 0;

  function automatic logic [63:0] enc(input logic [63:0] x);
    return {x[56:0], x[63:57]} ^ C;
  endfunction

  function automatic logic [63:0] dec(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ C;
    return {y[6:0], y[63:7]};
  endfunction

  assign in_v   = sel ? valid_b : valid_a;
  assign in_m   = sel ? mode_b : mode_a;
  assign in_d   = sel ? data_b : data_a;
  assign stub_v = pv[LAT-1] && !dead;
  assign vin_a  = stub_v && !sel;
  assign vin_b  = stub_v && sel;

  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], in_v};
    pd[0] <= in_m ? dec(in_d) : enc(in_d);
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end

  des_kat_selftest #(.TIMEOUT(TO), .DEC_EN(1'b1)) dut_a (
    .clk_i(clk), .reset_i(reset_n), .start_i(start_a),
    .des_mode_o(mode_a), .des_key_o(key_a), .des_data_o(data_a), .des_valid_o(valid_a),
    .des_data_i(pd[LAT-1]), .des_valid_i(vin_a),
    .rom_addr_o(addr_a), .rom_data_i(rom[addr_a]),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .err_cnt_o(err_a),
    .first_err_o(first_a), .timeout_o(tout_a)
  );

  des_kat_selftest #(.TIMEOUT(TO), .DEC_EN(1'b0)) dut_b (
    .clk_i(clk), .reset_i(reset_n), .start_i(start_b),
    .des_mode_o(mode_b), .des_key_o(key_b), .des_data_o(data_b), .des_valid_o(valid_b),
    .des_data_i(pd[LAT-1]), .des_valid_i(vin_b),
    .rom_addr_o(addr_b), .rom_data_i(rom[addr_b]),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .err_cnt_o(err_b),
    .first_err_o(first_b), .timeout_o(tout_b)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected issue stream for one run, consumed by the monitor.
  task automatic push_run(input bit with_dec);
    for (int i = 0; i < 64; i++) sb.push_back('{mode: 1'b0, data: 64'h8000_0000_0000_0000 >> i});
    if (with_dec) for (int i = 0; i < 64; i++) sb.push_back('{mode: 1'b1, data: rom[i]});
  endtask

  task automatic wait_done(input bit on_b, input int limit, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < limit) begin
      @(negedge clk);
      cyc++;
      seen = on_b ? done_b : done_a;
    end
    chk("done_seen", {71'd0, seen}, 72'd1);
    @(negedge clk);
    chk("done_one_cycle", {71'd0, on_b ? done_b : done_a}, 72'd0);
  endtask

  always @(negedge clk) begin
    iss_t obs, exp;
    int   n;
    if (sel ? valid_b : valid_a) begin
      obs = '{mode: sel ? mode_b : mode_a, data: sel ? data_b : data_a};
      n   = sb.size();
      chk("issue_expected", 72'(n != 0), 72'd1);
      if (n != 0) begin
        exp = sb.pop_front();
        chk("issue_word", 72'(obs), 72'(exp));
      end
    end
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (vin_a) outs_a++;
  end

  task automatic start_pulse_a();
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("busy_after_start", {71'd0, busy_a}, 72'd1);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; dead = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = enc(64'h8000_0000_0000_0000 >> i);

    // Reset, then 100 idle cycles with no start.
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_busy", {71'd0, busy_a}, 72'd0);
    chk("rst_valid", {71'd0, valid_a}, 72'd0);
    chk("rst_done", {71'd0, done_a}, 72'd0);
    chk("rst_pass", {71'd0, pass_a}, 72'd0);
    chk("rst_timeout", {71'd0, tout_a}, 72'd0);
    chk("rst_mode", {71'd0, mode_a}, 72'd0);
    chk("rst_data", 72'(data_a), 72'd0);
    chk("rst_key", 72'(key_a), 72'h0101_0101_0101_0101);
    chk("rst_addr", 72'(addr_a), 72'd0);
    chk("rst_err", 72'(err_a), 72'd0);
    chk("rst_first", 72'(first_a), 72'h7F);
    chk("rst_b_first", 72'(first_b), 72'h7F);

    // Clean run, ENC + DEC.
    push_run(1'b1);
    start_pulse_a();
    wait_done(1'b0, 800, cyc);
    chk("clean_pass", {71'd0, pass_a}, 72'd1);
    chk("clean_err", 72'(err_a), 72'd0);
    chk("clean_first", 72'(first_a), 72'h7F);
    chk("clean_timeout", {71'd0, tout_a}, 72'd0);
    chk("clean_busy", {71'd0, busy_a}, 72'd0);
    chk("clean_sb_empty", 72'(sb.size()), 72'd0);
    chk("clean_done_cnt", 72'(done_cnt_a), 72'd1);

    // ROM[5] corrupted: one ENC and one DEC mismatch at index 5.
    rom[5] = rom[5] ^ 64'd1;
    push_run(1'b1);
    start_pulse_a();
    chk("restart_clears_pass", {71'd0, pass_a}, 72'd0);
    wait_done(1'b0, 800, cyc);
    chk("bad_err", 72'(err_a), 72'd2);
    chk("bad_first", 72'(first_a), 72'h05);
    chk("bad_pass", {71'd0, pass_a}, 72'd0);
    rom[5] = rom[5] ^ 64'd1;

    // des never answers: timeout after all 64 issues.
    dead = 1'b1;
    push_run(1'b0);
    start_pulse_a();
    wait_done(1'b0, 1000, cyc);
    chk("to_window", 72'((cyc >= 64 + TO) && (cyc <= 64 + TO + 2)), 72'd1);
    chk("to_flag", {71'd0, tout_a}, 72'd1);
    chk("to_pass", {71'd0, pass_a}, 72'd0);
    chk("to_err", 72'(err_a), 72'd0);
    chk("to_sb_empty", 72'(sb.size()), 72'd0);
    dead = 1'b0;

    // Reset in the middle of ENC: no done pulse, then a clean rerun.
    cyc = done_cnt_a;
    outs_a = 0;
    push_run(1'b1);
    start_pulse_a();
    for (int i = 0; i < 200 && outs_a < 30; i++) @(negedge clk);
    chk("mid_reached", 72'(outs_a >= 30), 72'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    chk("mid_busy", {71'd0, busy_a}, 72'd0);
    chk("mid_valid", {71'd0, valid_a}, 72'd0);
    repeat (20) @(negedge clk);
    chk("mid_no_done", 72'(done_cnt_a), 72'(cyc));
    push_run(1'b1);
    start_pulse_a();
    wait_done(1'b0, 800, cyc);
    chk("mid_rerun_pass", {71'd0, pass_a}, 72'd1);

    // DEC_EN=0 instance, start held for 3 cycles.
    sel = 1'b1;
    push_run(1'b0);
    @(negedge clk);
    start_b = 1'b1;
    repeat (3) @(negedge clk);
    start_b = 1'b0;
    wait_done(1'b1, 800, cyc);
    repeat (20) @(negedge clk);
    chk("b_pass", {71'd0, pass_b}, 72'd1);
    chk("b_err", 72'(err_b), 72'd0);
    chk("b_done_cnt", 72'(done_cnt_b), 72'd1);
    chk("b_sb_empty", 72'(sb.size()), 72'd0);
    chk("b_busy", {71'd0, busy_b}, 72'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
